// File: rtl/hmem_responder.sv
// hmem_responder: word-addressed backing memory with fixed response latency; define HMEM_RANDOM_LATENCY_EN to add 0..3 cycles of LFSR jitter
module hmem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 4096,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_operation,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_address,
  input  logic [XLEN-1:0] req_store_word,
  output logic [XLEN-1:0] req_loaded_word,
  output logic            req_fulfilled,
  output logic            req_error,
  output logic            busy
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int CW    = $clog2(LATENCY + 4) + 1;

  if (XLEN != 32) begin : g_bad_xlen
    $error("hmem_responder: XLEN must be 32");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("hmem_responder: LATENCY must be >= 1");
  end
  if ((MEM_BYTES < 4) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_mem
    $error("hmem_responder: MEM_BYTES must be a power of two and a multiple of 4");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_op;
  logic [1:0]      r_size;
  logic [AW-3:0]   r_idx;
  logic [1:0]      r_lo;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_loaded;
  logic            r_ful;
  logic            r_err;
  logic [XLEN-1:0] r_mem [WORDS] = '{default: '0};

  logic            w_accept;
  logic            w_fire;
  logic            w_err;
  logic            w_write;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_cur;
  logic [XLEN-1:0] w_merged;
  logic [XLEN-1:0] w_resp;
  logic [CW-1:0]   w_lat0;
  logic            w_unused_addr;

  // The pulse cycle doubles as an accept slot so back-to-back requests cost LATENCY+1
  assign w_accept = req_valid && (r_state == IDLE || r_state == RESP);
  assign w_fire   = (r_state == WAIT) && (r_cnt == '0);
  assign w_err    = (r_size == 2'd3) || (r_size == 2'd2 && r_lo != 2'd0) || (r_size == 2'd1 && r_lo[0]);
  assign w_write  = w_fire && r_op && !w_err;
  assign w_be     = r_size == 2'd0 ? 4'b0001 << r_lo : r_size == 2'd1 ? (r_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata  = r_size == 2'd0 ? {4{r_data[7:0]}} : r_size == 2'd1 ? {2{r_data[15:0]}} : r_data;
  assign w_cur    = r_mem[r_idx];
  assign w_resp   = w_err ? '0 : r_op ? w_merged : w_cur;
  assign w_unused_addr = ^req_address[XLEN-1:AW];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : w_cur[8*i +: 8];
  end

`ifdef HMEM_RANDOM_LATENCY_EN
  logic [7:0] r_lfsr;
  // Galois LFSR (x^8+x^6+x^5+x^4+1) stepped once per accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 8'hA5;
    else if (w_accept) r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
  end
  assign w_lat0 = CW'(LATENCY - 1) + CW'(r_lfsr[1:0]);
`else
  assign w_lat0 = CW'(LATENCY - 1);
`endif

  // Array write lands on the edge that enters RESP; an asserted reset suppresses it
  always_ff @(posedge clk) begin
    if (w_write && !reset) r_mem[r_idx] <= w_merged;
  end

  // Request FSM: latch at accept, count down in WAIT, register the one-cycle response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_size   <= 2'd0;
      r_idx    <= '0;
      r_lo     <= 2'd0;
      r_data   <= '0;
      r_loaded <= '0;
      r_ful    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ful <= 1'b0;
      r_err <= 1'b0;
      if (w_accept) begin
        r_state <= WAIT;
        r_cnt   <= w_lat0;
        r_op    <= req_operation;
        r_size  <= req_size;
        r_idx   <= req_address[AW-1:2];
        r_lo    <= req_address[1:0];
        r_data  <= req_store_word;
      end else if (r_state == RESP) begin
        r_state <= IDLE;
      end else if (w_fire) begin
        r_state  <= RESP;
        r_ful    <= !w_err;
        r_err    <= w_err;
        r_loaded <= w_resp;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign req_loaded_word = r_loaded;
  assign req_fulfilled   = r_ful;
  assign req_error       = r_err;
  assign busy            = r_state != IDLE;
endmodule
